traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 19 +
 rtl/tl_phase_timer.sv | 38 +++
 rtl/traffic_light_ctrl.sv | 154 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and default durations for the intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  localparam int DEF_N_DIR     = 2;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_GREEN_T   = 60;
  localparam int DEF_YELLOW_T  = 5;
  localparam int DEF_ALLRED_T  = 3;
  localparam int DEF_MIN_GREEN = 10;
  localparam int DEF_FLASH_T   = 4;

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable phase down-counter; holds at 1 until reloaded, so 0 is never reached.
module tl_phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             shorten,
  input  logic [CNT_W-1:0] short_val,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;

  // A phase change always wins over a shortening request.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (shorten) begin
      count_d = short_val;
    end else if (count_q > CNT_W'(1)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= CNT_W'(RST_VAL);
    else     count_q <= count_d;
  end

  assign count  = count_q;
  assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach intersection controller: green/yellow/all-red rotation,
// request-driven green shortening and a night-flash mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR     = DEF_N_DIR,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GREEN_T   = DEF_GREEN_T,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int FLASH_T   = DEF_FLASH_T,
  localparam int DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DIR-1:0] pass_req,
  input  logic             flash_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [DIR_W-1:0] active_dir,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] countdown
);

  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] FLASH_C  = CNT_W'(FLASH_T);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(N_DIR - 1);
  localparam logic [N_DIR-1:0] ONE_HOT0 = N_DIR'(1);

  phase_e           phase_q, phase_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             flash_on_q, flash_on_d;
  logic [N_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;

  logic             load, shorten, expire;
  logic [CNT_W-1:0] load_val, count;
  logic [N_DIR-1:0] sel_q, sel_d;

  assign sel_q   = ONE_HOT0 << dir_q;
  assign sel_d   = ONE_HOT0 << dir_d;
  assign shorten = (phase_q == PH_GREEN) && (|(pass_req & ~sel_q)) && (count > MIN_C);

  tl_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_T)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .shorten   (shorten),
    .short_val (MIN_C),
    .count     (count),
    .expire    (expire)
  );

  // Phase FSM: every transition happens on the last cycle of a phase.
  always_comb begin
    phase_d    = phase_q;
    dir_d      = dir_q;
    flash_on_d = flash_on_q;
    load       = 1'b0;
    load_val   = ALLRED_C;
    if (expire) begin
      load = 1'b1;
      unique case (phase_q)
        PH_GREEN: begin
          phase_d  = PH_YELLOW;
          load_val = YELLOW_C;
        end
        PH_YELLOW: begin
          phase_d  = PH_ALLRED;
          load_val = ALLRED_C;
        end
        PH_ALLRED: begin
          if (flash_en) begin
            phase_d    = PH_FLASH;
            flash_on_d = 1'b1;
            load_val   = FLASH_C;
          end else begin
            phase_d  = PH_GREEN;
            dir_d    = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
            load_val = GREEN_C;
          end
        end
        PH_FLASH: begin
          // An on half always completes into an off half; exit only from off.
          if (flash_on_q || flash_en) begin
            flash_on_d = ~flash_on_q;
            load_val   = FLASH_C;
          end else begin
            phase_d    = PH_ALLRED;
            flash_on_d = 1'b0;
            dir_d      = LAST_DIR;
            load_val   = ALLRED_C;
          end
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so they switch with phase and countdown.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    unique case (phase_d)
      PH_GREEN: begin
        green_d = sel_d;
        red_d   = ~sel_d;
      end
      PH_YELLOW: begin
        yellow_d = sel_d;
        red_d    = ~sel_d;
      end
      PH_ALLRED: red_d = '1;
      PH_FLASH: begin
        red_d    = '0;
        yellow_d = {N_DIR{flash_on_d}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_ALLRED;
      dir_q      <= LAST_DIR;
      flash_on_q <= 1'b0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      flash_on_q <= flash_on_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
    end
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;
  assign countdown  = count;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with default parameters (two approaches).
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int N_DIR     = 2;
  localparam int CNT_W     = 8;
  localparam int GREEN_T   = 60;
  localparam int YELLOW_T  = 5;
  localparam int ALLRED_T  = 3;
  localparam int MIN_GREEN = 10;
  localparam int FLASH_T   = 4;
  localparam int DIR_W     = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_DIR-1:0] pass_req;
  logic             flash_en;
  logic [N_DIR-1:0] red, yellow, green;
  logic [DIR_W-1:0] active_dir;
  logic [1:0]       phase;
  logic [CNT_W-1:0] countdown;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];
  int allred_run = 0;
  logic [N_DIR-1:0] prev_green = '0;

  traffic_light_ctrl #(
    .N_DIR     (N_DIR),
    .CNT_W     (CNT_W),
    .GREEN_T   (GREEN_T),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .MIN_GREEN (MIN_GREEN),
    .FLASH_T   (FLASH_T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pass_req   (pass_req),
    .flash_en   (flash_en),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .phase      (phase),
    .countdown  (countdown)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    if (MIN_GREEN < 1 || MIN_GREEN >= GREEN_T || N_DIR < 2 ||
        GREEN_T >= (1 << CNT_W)) begin
      $display("FAIL params: illegal parameter set");
      $fatal(1);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Driver tasks; the bench always sits on a falling edge between steps.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_st(input string tag, input logic [1:0] ph, input logic [DIR_W-1:0] d,
                           input int cnt, input logic [1:0] r, input logic [1:0] y,
                           input logic [1:0] g);
    check_eq({tag, ".phase"}, 32'(phase), 32'(ph));
    check_eq({tag, ".dir"}, 32'(active_dir), 32'(d));
    check_eq({tag, ".cnt"}, 32'(countdown), cnt);
    check_eq({tag, ".red"}, 32'(red), 32'(r));
    check_eq({tag, ".yellow"}, 32'(yellow), 32'(y));
    check_eq({tag, ".green"}, 32'(green), 32'(g));
  endtask

  // Scoreboard: one-hot green and all-red clearance before every new green.
  always @(negedge clk) begin
    check_eq("one_hot_green", 32'($onehot0(green)), 32'd1);
    if (green != '0 && prev_green == '0)
      check_eq("clearance", 32'(allred_run >= ALLRED_T), 32'd1);
    if (red == '1) allred_run++;
    else           allred_run = 0;
    prev_green = green;
  end

  initial begin
    rst      = 1'b1;
    pass_req = '0;
    flash_en = 1'b0;
    step(2);
    rst = 1'b0;
    expect_st("reset", PH_ALLRED, 1'b1, 3, 2'b11, 2'b00, 2'b00);

    // Free run
    step(3);
    expect_st("first_green", PH_GREEN, 1'b0, 60, 2'b10, 2'b00, 2'b01);
    step(59);
    expect_st("green_last", PH_GREEN, 1'b0, 1, 2'b10, 2'b00, 2'b01);
    step(1);
    expect_st("yellow0", PH_YELLOW, 1'b0, 5, 2'b10, 2'b01, 2'b00);
    step(4);
    expect_st("yellow0_last", PH_YELLOW, 1'b0, 1, 2'b10, 2'b01, 2'b00);
    step(1);
    expect_st("allred0", PH_ALLRED, 1'b0, 3, 2'b11, 2'b00, 2'b00);
    step(3);
    expect_st("green1", PH_GREEN, 1'b1, 60, 2'b01, 2'b00, 2'b10);
    step(68);
    expect_st("wrap_green0", PH_GREEN, 1'b0, 60, 2'b10, 2'b00, 2'b01);

    // Own-approach request ignored, other-approach request shortens
    step(19);
    pass_req = 2'b01;
    step(1);
    expect_st("own_req_ignored", PH_GREEN, 1'b0, 40, 2'b10, 2'b00, 2'b01);
    pass_req = 2'b10;
    step(1);
    pass_req = 2'b00;
    expect_st("shortened", PH_GREEN, 1'b0, 10, 2'b10, 2'b00, 2'b01);
    step(9);
    expect_st("short_last", PH_GREEN, 1'b0, 1, 2'b10, 2'b00, 2'b01);
    step(1);
    expect_st("short_yellow", PH_YELLOW, 1'b0, 5, 2'b10, 2'b01, 2'b00);
    step(8);
    expect_st("green1_b", PH_GREEN, 1'b1, 60, 2'b01, 2'b00, 2'b10);

    // Request at or below the minimum has no effect
    step(52);
    pass_req = 2'b01;
    step(1);
    pass_req = 2'b00;
    expect_st("req_below_min", PH_GREEN, 1'b1, 7, 2'b01, 2'b00, 2'b10);
    step(6);
    pass_req = 2'b01;
    step(1);
    expect_st("req_at_expire", PH_YELLOW, 1'b1, 5, 2'b01, 2'b10, 2'b00);
    pass_req = 2'b11;
    step(1);
    pass_req = 2'b00;
    expect_st("req_in_yellow", PH_YELLOW, 1'b1, 4, 2'b01, 2'b10, 2'b00);
    step(7);
    expect_st("green0_c", PH_GREEN, 1'b0, 60, 2'b10, 2'b00, 2'b01);

    // Flash requested during green only takes effect after clearance
    flash_en = 1'b1;
    step(60);
    expect_st("flash_yellow", PH_YELLOW, 1'b0, 5, 2'b10, 2'b01, 2'b00);
    step(5);
    expect_st("flash_allred", PH_ALLRED, 1'b0, 3, 2'b11, 2'b00, 2'b00);
    step(3);
    expect_st("flash_enter", PH_FLASH, 1'b0, 4, 2'b00, 2'b11, 2'b00);
    exp_q = {4'hF, 4'hF, 4'hF, 4'hC, 4'hC, 4'hC, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] e;
      step(1);
      e = exp_q.pop_front();
      check_eq($sformatf("flash_k%0d", k), {26'd0, phase, yellow, red[0] | green[0], red[1] | green[1]},
               {26'd0, e, 2'b00});
    end
    step(4);
    expect_st("flash_on2", PH_FLASH, 1'b0, 4, 2'b00, 2'b11, 2'b00);
    step(2);
    flash_en = 1'b0;
    step(2);
    expect_st("flash_off_final", PH_FLASH, 1'b0, 4, 2'b00, 2'b00, 2'b00);
    step(3);
    expect_st("flash_off_last", PH_FLASH, 1'b0, 1, 2'b00, 2'b00, 2'b00);
    step(1);
    expect_st("flash_exit", PH_ALLRED, 1'b1, 3, 2'b11, 2'b00, 2'b00);
    step(3);
    expect_st("after_flash", PH_GREEN, 1'b0, 60, 2'b10, 2'b00, 2'b01);

    // Reset in the middle of approach 1 yellow
    step(68);
    step(60);
    expect_st("yellow1", PH_YELLOW, 1'b1, 5, 2'b01, 2'b10, 2'b00);
    step(2);
    rst = 1'b1;
    #1;
    expect_st("async_rst", PH_ALLRED, 1'b1, 3, 2'b11, 2'b00, 2'b00);
    step(2);
    rst = 1'b0;
    expect_st("post_rst", PH_ALLRED, 1'b1, 3, 2'b11, 2'b00, 2'b00);
    step(3);
    expect_st("post_rst_green", PH_GREEN, 1'b0, 60, 2'b10, 2'b00, 2'b01);
    step(1);
    check_eq("post_rst_dec", 32'(countdown), 32'd59);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
